// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the parametrised FIFO controller:
//   - fifo_state_e : controller state encoding (INIT / RUN / FLUSH)
//   - FIFO_DEF_*   : default depth and flag thresholds
// -----------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fifo_state_e;

    localparam int FIFO_DEF_DEPTH    = 16;
    localparam int FIFO_DEF_AE_LEVEL = 2;
    localparam int FIFO_DEF_AF_GAP   = 2;   // almost_full sits this far below DEPTH

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
// AW-bit wrapping pointer with increment and synchronous zero. Wraps from
// 2**AW-1 to 0 by natural overflow of the register.
//
// Ports:
//   clk   in  1   clock, rising edge
//   rst   in  1   asynchronous active-high reset, pointer -> 0
//   zero  in  1   synchronous clear, wins over inc
//   inc   in  1   advance pointer by one
//   ptr   out AW  current pointer value (registered)
// -----------------------------------------------------------------------------
module fifo_ptr #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          zero,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (zero) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule : fifo_ptr

// File: rtl/fifo_ctrl_param.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_param
// Synchronous FIFO controller for an external simple dual-port RAM. Converts
// write/read requests into RAM strobes and addresses, tracks occupancy and
// derives full/empty/almost flags. Sticky overflow/underflow flags record
// requests that were refused because the FIFO was full/empty.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   clr                   synchronous flush (pointers and count to 0)
//   err_clr               synchronous clear of overflow/underflow
//   wr_en, rd_en          producer / consumer requests
//   mem_we, mem_waddr     RAM write strobe (combinational) and address (wptr)
//   mem_re, mem_raddr     RAM read strobe (combinational) and address (rptr)
//   rd_valid              RAM read data valid, one cycle after mem_re
//   full, empty           status flags
//   almost_full           count >= AF_LEVEL
//   almost_empty          count <= AE_LEVEL
//   count                 occupancy 0..DEPTH
//   overflow, underflow   sticky error flags
// -----------------------------------------------------------------------------
module fifo_ctrl_param
    import fifo_pkg::*;
#(
    parameter int DEPTH    = FIFO_DEF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - FIFO_DEF_AF_GAP,
    parameter int AE_LEVEL = FIFO_DEF_AE_LEVEL
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          err_clr,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic          mem_re,
    output logic [AW-1:0] mem_raddr,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

    fifo_state_e state_q, state_d;
    logic [AW:0] count_q, count_d;
    logic        rd_valid_q, rd_valid_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;

    logic        run;        // RUN and no flush request this cycle
    logic        wa;         // accepted write
    logic        ra;         // accepted read
    logic        ptr_zero;   // clear both pointers
    logic        full_i;
    logic        empty_i;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // ---------------------------------------------------------------------
    // Status decode from registered count and state. Outside RUN the FIFO
    // looks empty to both sides so no request can be accepted.
    // ---------------------------------------------------------------------
    always_comb begin
        full_i       = 1'b0;
        empty_i      = 1'b1;
        almost_full  = 1'b0;
        almost_empty = 1'b1;
        if (state_q == ST_RUN) begin
            full_i       = (count_q == DEPTH_C);
            empty_i      = (count_q == '0);
            almost_full  = (count_q >= AF_C);
            almost_empty = (count_q <= AE_C);
        end
    end

    assign full  = full_i;
    assign empty = empty_i;

    // clr has priority over requests: a flush cycle accepts nothing and
    // flags no errors.
    assign run = (state_q == ST_RUN) && !clr;
    assign wa  = run && wr_en && !full_i;
    assign ra  = run && rd_en && !empty_i;

    // Pointers and count are zeroed on the clr edge and held there through
    // the FLUSH cycle.
    assign ptr_zero = ((state_q == ST_RUN) && clr) || (state_q == ST_FLUSH);

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT:  state_d = ST_RUN;
            ST_RUN:   if (clr) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_INIT;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (ptr_zero) begin
            count_d = '0;
        end else begin
            unique case ({wa, ra})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Set wins over err_clr when both happen in the same cycle.
    always_comb begin
        rd_valid_d  = ra;
        overflow_d  = (overflow_q  && !err_clr) || (run && wr_en && full_i);
        underflow_d = (underflow_q && !err_clr) || (run && rd_en && empty_i);
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ptr #(.AW(AW)) u_wptr (
        .clk  (clk),
        .rst  (rst),
        .zero (ptr_zero),
        .inc  (wa),
        .ptr  (wptr)
    );

    fifo_ptr #(.AW(AW)) u_rptr (
        .clk  (clk),
        .rst  (rst),
        .zero (ptr_zero),
        .inc  (ra),
        .ptr  (rptr)
    );

    assign mem_we    = wa;
    assign mem_re    = ra;
    assign mem_waddr = wptr;
    assign mem_raddr = rptr;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule : fifo_ctrl_param
